// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer for the shared iterative multiplier and divider.
// Owns the architectural HI/LO registers. It issues one-cycle start pulses
// to the Mult/Div units. It stalls only HI/LO-class instructions while an
// operation is in flight.
module hilo_muldiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        busy,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        mul_start,
  output logic        mul_sign,
  input  logic        mul_done,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        div_start,
  output logic        div_sign,
  input  logic        div_done,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero,
  output logic        timeout
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MUL_WAIT = 2'd1;
  localparam logic [1:0] DIV_WAIT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             hilo_class;
  logic             act_done;
  logic [31:0]      act_hi;
  logic [31:0]      act_lo;

  // Decode HI/LO-class funct codes
  always_comb begin
    hilo_class = 1'b0;
    case (funct)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_MULT, F_MULTU, F_DIV, F_DIVU: hilo_class = 1'b1;
      default:                        hilo_class = 1'b0;
    endcase
  end

  assign busy    = (state != IDLE);
  assign stall   = busy & op_valid & hilo_class;
  assign cnt_inc = cnt + CNT_ONE;

  // Select the active unit's result. A done that arrives in the start-pulse
  // cycle is stale (left over from a previous op), so it is masked out.
  always_comb begin
    act_done = 1'b0;
    act_hi   = mul_hi;
    act_lo   = mul_lo;
    if (state == MUL_WAIT) begin
      act_done = mul_done & ~mul_start;
    end else if (state == DIV_WAIT) begin
      act_done = div_done & ~div_start;
      act_hi   = div_hi;
      act_lo   = div_lo;
    end
  end

  // Sequencer FSM, HI/LO registers and operand latches
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      mul_start <= 1'b0;
      div_start <= 1'b0;
      mul_sign  <= 1'b0;
      div_sign  <= 1'b0;
      div_zero  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      div_start <= 1'b0;
      div_zero  <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (op_valid) begin
            case (funct)
              F_MTHI: hi <= src_a;
              F_MTLO: lo <= src_a;
              F_MULT, F_MULTU: begin
                op_a      <= src_a;
                op_b      <= src_b;
                mul_sign  <= (funct == F_MULT);
                mul_start <= 1'b1;
                state     <= MUL_WAIT;
              end
              F_DIV, F_DIVU: begin
                if (src_b == 32'd0) begin
                  div_zero <= 1'b1;
                end else begin
                  op_a      <= src_a;
                  op_b      <= src_b;
                  div_sign  <= (funct == F_DIV);
                  div_start <= 1'b1;
                  state     <= DIV_WAIT;
                end
              end
              default: ;
            endcase
          end
        end
        MUL_WAIT, DIV_WAIT: begin
          // done beats the timeout when both land in the same cycle
          if (act_done) begin
            hi    <= act_hi;
            lo    <= act_lo;
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_inc == CNT_LIM) begin
            timeout <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: an IDLE-op vector table plus
// hand-written multi-cycle sequences (mul/div completion, stall, timeout,
// reset mid-operation).
module tb_hilo_muldiv_ctrl;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU  = 6'b100001;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b;
  logic        stall, busy;
  logic [31:0] op_a, op_b;
  logic        mul_start, mul_sign, mul_done;
  logic [31:0] mul_hi, mul_lo;
  logic        div_start, div_sign, div_done;
  logic [31:0] div_hi, div_lo;
  logic [31:0] hi, lo;
  logic        div_zero, timeout;

  int tests = 0;
  int fails = 0;

  hilo_muldiv_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .funct(funct),
    .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy),
    .op_a(op_a), .op_b(op_b), .mul_start(mul_start), .mul_sign(mul_sign),
    .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_start(div_start), .div_sign(div_sign), .div_done(div_done),
    .div_hi(div_hi), .div_lo(div_lo), .hi(hi), .lo(lo),
    .div_zero(div_zero), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        dz;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // advance one clock and settle just past the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    op_valid = v;
    funct    = f;
    src_a    = a;
    src_b    = b;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    mul_done = 1'b0; mul_hi = 32'd0; mul_lo = 32'd0;
    div_done = 1'b0; div_hi = 32'd0; div_lo = 32'd0;

    vt[0] = '{1'b1, F_MTHI, 32'h1234, 32'd0, 1'b0, 32'h1234, 32'h0,    1'b0, 1'b0};
    vt[1] = '{1'b1, F_MTLO, 32'h5678, 32'd0, 1'b0, 32'h1234, 32'h5678, 1'b0, 1'b0};
    vt[2] = '{1'b0, F_MTHI, 32'hFFFF, 32'd0, 1'b0, 32'h1234, 32'h5678, 1'b0, 1'b0};
    vt[3] = '{1'b1, F_ADDU, 32'hFFFF, 32'd0, 1'b0, 32'h1234, 32'h5678, 1'b0, 1'b0};
    vt[4] = '{1'b1, F_MFHI, 32'd0,    32'd0, 1'b0, 32'h1234, 32'h5678, 1'b0, 1'b0};
    vt[5] = '{1'b1, F_DIV,  32'h99,   32'd0, 1'b0, 32'h1234, 32'h5678, 1'b0, 1'b1};
    vt[6] = '{1'b1, F_MFLO, 32'd0,    32'd0, 1'b0, 32'h1234, 32'h5678, 1'b0, 1'b0};
    vt[7] = '{1'b1, F_DIVU, 32'd7,    32'd0, 1'b0, 32'h1234, 32'h5678, 1'b0, 1'b1};
    vt[8] = '{1'b1, F_MTLO, 32'h0BAD, 32'd0, 1'b0, 32'h1234, 32'h0BAD, 1'b0, 1'b0};
    vt[9] = '{1'b1, F_MTHI, 32'hCAFE, 32'd0, 1'b0, 32'hCAFE, 32'h0BAD, 1'b0, 1'b0};

    // reset state
    cyc(); cyc();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_starts", {30'd0, mul_start, div_start}, 32'd0);
    chk("rst_pulses", {30'd0, div_zero, timeout}, 32'd0);
    reset = 1'b0;

    // IDLE single-cycle ops, including divide-by-zero refusal
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].vld, vt[i].fn, vt[i].a, vt[i].b);
      #1 chk($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vt[i].stall});
      cyc();
      chk($sformatf("vec%0d_hi", i), hi, vt[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vt[i].lo);
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].busy});
      chk($sformatf("vec%0d_div_zero", i), {31'd0, div_zero}, {31'd0, vt[i].dz});
      chk($sformatf("vec%0d_div_start", i), {31'd0, div_start}, 32'd0);
    end
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    cyc();

    // MULT 0xFFFFFFFE * 3, unit responds 4 cycles after the start pulse
    drive(1'b1, F_MULT, 32'hFFFFFFFE, 32'd3);
    #1 chk("mul_acc_stall", {31'd0, stall}, 32'd0);
    cyc();
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    chk("mul_busy", {31'd0, busy}, 32'd1);
    chk("mul_start_hi", {31'd0, mul_start}, 32'd1);
    chk("mul_sign", {31'd0, mul_sign}, 32'd1);
    chk("mul_op_a", op_a, 32'hFFFFFFFE);
    chk("mul_op_b", op_b, 32'd3);
    cyc();
    chk("mul_start_lo", {31'd0, mul_start}, 32'd0);
    cyc(); cyc();
    chk("mul_op_a_hold", op_a, 32'hFFFFFFFE);
    mul_done = 1'b1; mul_hi = 32'hFFFFFFFF; mul_lo = 32'hFFFFFFFA;
    #1 chk("mul_busy_pre_done", {31'd0, busy}, 32'd1);
    cyc();
    mul_done = 1'b0;
    chk("mul_busy_post", {31'd0, busy}, 32'd0);
    chk("mul_hi_res", hi, 32'hFFFFFFFF);
    chk("mul_lo_res", lo, 32'hFFFFFFFA);

    // DIVU 100/7, 5 independent ADDUs, then a dependent MFLO
    drive(1'b1, F_DIVU, 32'd100, 32'd7);
    cyc();
    chk("div_busy", {31'd0, busy}, 32'd1);
    chk("div_start_hi", {31'd0, div_start}, 32'd1);
    chk("div_sign", {31'd0, div_sign}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, F_ADDU, 32'd1, 32'd2);
      mul_done = (k == 2);   // inactive unit's done must be ignored
      mul_hi = 32'h77; mul_lo = 32'h77;
      #1 chk($sformatf("addu%0d_stall", k), {31'd0, stall}, 32'd0);
      cyc();
      chk($sformatf("addu%0d_busy", k), {31'd0, busy}, 32'd1);
    end
    mul_done = 1'b0;
    chk("div_hi_untouched", hi, 32'hFFFFFFFF);
    drive(1'b1, F_MFLO, 32'd0, 32'd0);
    #1 chk("mflo_stall0", {31'd0, stall}, 32'd1);
    cyc();
    div_done = 1'b1; div_hi = 32'd2; div_lo = 32'd14;
    #1 chk("mflo_stall_done", {31'd0, stall}, 32'd1);
    cyc();
    div_done = 1'b0;
    chk("div_busy_post", {31'd0, busy}, 32'd0);
    chk("div_lo_res", lo, 32'd14);
    chk("div_hi_res", hi, 32'd2);
    #1 chk("mflo_stall_drop", {31'd0, stall}, 32'd0);
    cyc();

    // MTHI while MULT in flight; a done in the start cycle is stale
    drive(1'b1, F_MULT, 32'd2, 32'd3);
    cyc();
    chk("mthi_mul_busy", {31'd0, busy}, 32'd1);
    drive(1'b1, F_MTHI, 32'hDEADBEEF, 32'd0);
    mul_done = 1'b1; mul_hi = 32'h5; mul_lo = 32'h5;
    #1 chk("mthi_stall_a", {31'd0, stall}, 32'd1);
    cyc();
    mul_done = 1'b0;
    chk("start_cycle_done_ignored", {31'd0, busy}, 32'd1);
    chk("mthi_hi_held", hi, 32'd2);
    #1 chk("mthi_stall_b", {31'd0, stall}, 32'd1);
    cyc();
    mul_done = 1'b1; mul_hi = 32'd0; mul_lo = 32'd6;
    #1 chk("mthi_stall_done", {31'd0, stall}, 32'd1);
    cyc();
    mul_done = 1'b0;
    chk("mthi_mul_idle", {31'd0, busy}, 32'd0);
    chk("mthi_mul_hi", hi, 32'd0);
    chk("mthi_mul_lo", lo, 32'd6);
    #1 chk("mthi_stall_drop", {31'd0, stall}, 32'd0);
    cyc();
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_lo", lo, 32'd6);
    drive(1'b0, 6'd0, 32'd0, 32'd0);

    // MULTU with no done: timeout after 8 WAIT cycles
    drive(1'b1, F_MULTU, 32'd5, 32'd5);
    cyc();
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    chk("to_mul_sign", {31'd0, mul_sign}, 32'd0);
    for (int w = 1; w < 8; w++) begin
      cyc();
      chk($sformatf("to_wait%0d", w), {30'd0, busy, timeout}, 32'd2);
    end
    cyc();
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    chk("to_hi", hi, 32'hDEADBEEF);
    chk("to_lo", lo, 32'd6);
    mul_done = 1'b1; mul_hi = 32'h11; mul_lo = 32'h22;
    cyc();
    mul_done = 1'b0;
    chk("to_pulse_end", {31'd0, timeout}, 32'd0);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_hi", hi, 32'hDEADBEEF);
    chk("stray_lo", lo, 32'd6);

    // reset 3 cycles into DIV_WAIT; late div_done ignored
    drive(1'b1, F_DIV, 32'd50, 32'd5);
    cyc();
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    chk("rdiv_sign", {31'd0, div_sign}, 32'd1);
    chk("rdiv_busy", {31'd0, busy}, 32'd1);
    cyc(); cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rdiv_hi", hi, 32'd0);
    chk("rdiv_lo", lo, 32'd0);
    chk("rdiv_busy_post", {31'd0, busy}, 32'd0);
    chk("rdiv_sign_clr", {31'd0, div_sign}, 32'd0);
    cyc();
    div_done = 1'b1; div_hi = 32'd0; div_lo = 32'd10;
    cyc();
    div_done = 1'b0;
    chk("late_done_hi", hi, 32'd0);
    chk("late_done_lo", lo, 32'd0);
    chk("late_done_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
